// File: rtl/modem_pkg.sv
// Shared definitions for the 2-bit-per-symbol modulator/demodulator pair:
// symbol timing defaults, symbol-to-chip mapping and FSM state encoding.
package modem_pkg;

    localparam int FREQ_DIV_DEFAULT = 128;
    localparam int CNT_W_DEFAULT    = 8;

    // Chip pair per symbol, packed as {chipA, chipB}
    localparam logic [1:0] CHIPS_SYM00 = 2'b00;
    localparam logic [1:0] CHIPS_SYM01 = 2'b10;
    localparam logic [1:0] CHIPS_SYM10 = 2'b11;
    localparam logic [1:0] CHIPS_SYM11 = 2'b01;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } mod_state_t;

    function automatic logic [1:0] sym_to_chips(input logic [1:0] sym);
        logic [1:0] chips;
        case (sym)
            2'b00:   chips = CHIPS_SYM00;
            2'b01:   chips = CHIPS_SYM01;
            2'b10:   chips = CHIPS_SYM10;
            default: chips = CHIPS_SYM11;
        endcase
        return chips;
    endfunction

endpackage

// File: rtl/symbol_modulator_if.sv
// Symbol input handshake plus modulated outputs of the symbol modulator.
// The source side uses master, the modulator uses slave.
interface symbol_modulator_if;
    logic [1:0] sym_in;
    logic       sym_valid;
    logic       sym_ready;
    logic       dout;
    logic       clk_symbol;
    logic       busy;

    modport master (
        output sym_in,
        output sym_valid,
        input  sym_ready,
        input  dout,
        input  clk_symbol,
        input  busy
    );

    modport slave (
        input  sym_in,
        input  sym_valid,
        output sym_ready,
        output dout,
        output clk_symbol,
        output busy
    );
endinterface

// File: rtl/symbol_phase_counter.sv
// Phase counter within one symbol period; restart has priority over enable.
// last flags the final phase so the FSM can load the next symbol seamlessly.
module symbol_phase_counter #(
    parameter int FREQ_DIV = 128,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             restart,
    output logic [CNT_W-1:0] phase,
    output logic             last
);

    localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(FREQ_DIV - 1);

    logic [CNT_W-1:0] phase_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q <= '0;
        end else if (restart) begin
            phase_q <= '0;
        end else if (enable) begin
            phase_q <= phase_q + 1'b1;
        end
    end

    assign phase = phase_q;
    assign last  = (phase_q == PHASE_LAST);

endmodule

// File: rtl/symbol_modulator.sv
// Transmit-side modulator: one-entry hold buffer feeding a two-state FSM that
// emits chipA, chipB, then silence per symbol, with a strobe on phase 0.
module symbol_modulator
    import modem_pkg::*;
#(
    parameter int FREQ_DIV = FREQ_DIV_DEFAULT,
    parameter int CNT_W    = CNT_W_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    symbol_modulator_if.slave   bus
);

    localparam logic [CNT_W-1:0] PHASE_QUARTER = CNT_W'(FREQ_DIV / 4);
    localparam logic [CNT_W-1:0] PHASE_HALF    = CNT_W'(FREQ_DIV / 2);

    mod_state_t       state_q, state_d;
    logic [1:0]       hold_sym_q;
    logic             hold_full_q, hold_full_d;
    logic [1:0]       cur_q, cur_d;
    logic             dout_q, dout_d;
    logic             strobe_q, strobe_d;

    logic             sym_ready;
    logic             accept;
    logic             load;
    logic             cnt_enable;
    logic             cnt_restart;
    logic [CNT_W-1:0] phase;
    logic [CNT_W-1:0] phase_nx;
    logic             phase_last;
    logic [1:0]       cur_chips;
    logic [1:0]       hold_chips;

    // Ready is gated by reset so nothing is taken while the block is held.
    assign sym_ready  = !hold_full_q && reset;
    assign accept     = bus.sym_valid && sym_ready;
    assign phase_nx   = phase + 1'b1;
    assign cur_chips  = sym_to_chips(cur_q);
    assign hold_chips = sym_to_chips(hold_sym_q);

    symbol_phase_counter #(
        .FREQ_DIV (FREQ_DIV),
        .CNT_W    (CNT_W)
    ) u_phase (
        .clk     (clk),
        .reset   (reset),
        .enable  (cnt_enable),
        .restart (cnt_restart),
        .phase   (phase),
        .last    (phase_last)
    );

    // Outputs are computed for the phase the counter will hold after this edge.
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        load        = 1'b0;
        cnt_enable  = 1'b0;
        cnt_restart = 1'b0;
        dout_d      = 1'b0;
        strobe_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hold_full_q) begin
                    load = 1'b1;
                end
            end
            ST_SEND: begin
                if (!phase_last) begin
                    cnt_enable = 1'b1;
                    if (phase_nx < PHASE_QUARTER) begin
                        dout_d = cur_chips[1];
                    end else if (phase_nx < PHASE_HALF) begin
                        dout_d = cur_chips[0];
                    end
                end else if (hold_full_q) begin
                    load = 1'b1;
                end else begin
                    state_d     = ST_IDLE;
                    cnt_restart = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cnt_restart = 1'b1;
            end
        endcase

        if (load) begin
            state_d     = ST_SEND;
            cur_d       = hold_sym_q;
            cnt_restart = 1'b1;
            strobe_d    = 1'b1;
            dout_d      = hold_chips[1];
        end
    end

    // Accept and load are mutually exclusive because ready is low while full.
    always_comb begin
        hold_full_d = hold_full_q;
        if (accept) begin
            hold_full_d = 1'b1;
        end else if (load) begin
            hold_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cur_q       <= '0;
            hold_sym_q  <= '0;
            hold_full_q <= 1'b0;
            dout_q      <= 1'b0;
            strobe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            hold_full_q <= hold_full_d;
            dout_q      <= dout_d;
            strobe_q    <= strobe_d;
            if (accept) begin
                hold_sym_q <= bus.sym_in;
            end
        end
    end

    assign bus.sym_ready  = sym_ready;
    assign bus.dout       = dout_q;
    assign bus.clk_symbol = strobe_q;
    assign bus.busy       = (state_q == ST_SEND);

endmodule

// File: tb/tb_symbol_modulator.sv
// Directed bench for symbol_modulator: a bench-side receiver decodes chips
// mid-chip after each strobe and checks timing, waveform and handshake.
module tb_symbol_modulator;

    localparam int FD = 128;
    localparam int CW = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    symbol_modulator_if bus ();

    symbol_modulator #(
        .FREQ_DIV (FD),
        .CNT_W    (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] tx_seq [16];
    logic [1:0] rx_sym [16];

    // {chipA, chipB} per symbol, written out by hand from the mapping table
    function automatic logic [1:0] exp_chips(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b00;
            2'b01:   return 2'b10;
            2'b10:   return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    function automatic logic [1:0] decode(input logic a, input logic b);
        case ({a, b})
            2'b00:   return 2'b00;
            2'b10:   return 2'b01;
            2'b11:   return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    // Drives tx_seq[0..n-1] and receives at negedges; junk=1 toggles valid
    // with wrong data whenever ready is low.
    task automatic run_stream(input int n, input bit junk,
                              output int rx_n, output int wave_err,
                              output int gap_err, output int ready_err,
                              output int strobes, output int ones,
                              output int busy_cyc, output int lat,
                              output bit timeout);
        int   sent, ph, last_strobe, first_strobe, xfer_cyc;
        bit   active, pending, done;
        logic a;
        logic exp;
        logic [1:0] chips;
        sent = 0; ph = 0; last_strobe = -1; first_strobe = -1; xfer_cyc = -1;
        active = 0; pending = 0; done = 0; a = 1'b0; chips = 2'b00;
        rx_n = 0; wave_err = 0; gap_err = 0; ready_err = 0;
        strobes = 0; ones = 0; busy_cyc = 0;
        for (int c = 0; c < n * FD + 300; c++) begin
            @(negedge clk);
            if (bus.clk_symbol === 1'b1) begin
                strobes++;
                if (last_strobe >= 0 && c - last_strobe != FD) gap_err++;
                if (first_strobe < 0) first_strobe = c;
                last_strobe = c;
                ph = 0;
                active = 1;
                if (strobes <= n) chips = exp_chips(tx_seq[strobes-1]);
                else wave_err++;
            end else if (active) begin
                ph++;
                if (ph == FD) active = 0;
            end
            if (active) begin
                exp = (ph < FD/4) ? chips[1] : (ph < FD/2) ? chips[0] : 1'b0;
                if (bus.dout !== exp) wave_err++;
                if (ph == FD/8) a = bus.dout;
                if (ph == 3*FD/8 && strobes <= 16) begin
                    rx_sym[strobes-1] = decode(a, bus.dout);
                    rx_n++;
                    $display("symbol %0d: sent %b decoded %b", strobes-1,
                             tx_seq[strobes-1], rx_sym[strobes-1]);
                end
            end else if (bus.dout !== 1'b0) begin
                wave_err++;
            end
            if (bus.dout === 1'b1) ones++;
            if (bus.busy === 1'b1) busy_cyc++;
            if (pending) begin
                sent++;
                if (sent == 1) xfer_cyc = c;
                if (bus.sym_ready !== 1'b0) ready_err++;
            end
            if (sent < n) begin
                if (junk && !bus.sym_ready) begin
                    bus.sym_valid = ~bus.sym_valid;
                    bus.sym_in    = ~tx_seq[sent];
                end else begin
                    bus.sym_valid = 1'b1;
                    bus.sym_in    = tx_seq[sent];
                end
            end else begin
                bus.sym_valid = 1'b0;
            end
            pending = bus.sym_valid && bus.sym_ready;
            if (sent == n && strobes >= n && !active && bus.busy === 1'b0) begin
                done = 1;
                break;
            end
        end
        bus.sym_valid = 1'b0;
        lat = (first_strobe >= 0 && xfer_cyc >= 0) ? first_strobe - xfer_cyc : -1;
        timeout = !done;
    endtask

    task automatic test_reset();
        bus.sym_valid = 1'b0;
        bus.sym_in    = 2'b00;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.sym_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_sym_ready: got %b expected 0", bus.sym_ready);
        end
        n_checks++;
        if (bus.dout !== 1'b0 || bus.clk_symbol !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got dout=%b strobe=%b busy=%b expected 0/0/0",
                     bus.dout, bus.clk_symbol, bus.busy);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.sym_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got ready=%b busy=%b expected 1/0",
                     bus.sym_ready, bus.busy);
        end
        $display("test_reset done");
    endtask

    task automatic test_single_symbol();
        int rx_n, we, ge, re, st, on, bc, lat;
        bit to;
        tx_seq[0] = 2'b10;
        run_stream(1, 0, rx_n, we, ge, re, st, on, bc, lat, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL single_timeout: got timeout expected completion"); end
        n_checks++;
        if (st != 1) begin n_fail++; $display("FAIL single_strobes: got %0d expected 1", st); end
        n_checks++;
        if (lat != 1) begin n_fail++; $display("FAIL single_latency: got %0d expected 1", lat); end
        n_checks++;
        if (on != FD/2) begin n_fail++; $display("FAIL single_dout_ones: got %0d expected %0d", on, FD/2); end
        n_checks++;
        if (bc != FD) begin n_fail++; $display("FAIL single_busy_cycles: got %0d expected %0d", bc, FD); end
        n_checks++;
        if (we != 0) begin n_fail++; $display("FAIL single_waveform: got %0d errors expected 0", we); end
        n_checks++;
        if (bus.sym_ready !== 1'b1) begin
            n_fail++; $display("FAIL single_ready_after: got %b expected 1", bus.sym_ready);
        end
    endtask

    task automatic test_all_symbols();
        int rx_n, we, ge, re, st, on, bc, lat;
        bit to;
        for (int s = 0; s < 4; s++) begin
            tx_seq[0] = 2'(s);
            rx_sym[0] = 2'bxx;
            run_stream(1, 0, rx_n, we, ge, re, st, on, bc, lat, to);
            n_checks++;
            if (to || rx_sym[0] !== 2'(s)) begin
                n_fail++;
                $display("FAIL symbol_decode_%0d: got %b (timeout=%0b) expected %b", s, rx_sym[0], to, 2'(s));
            end
            n_checks++;
            if (we != 0) begin
                n_fail++; $display("FAIL symbol_waveform_%0d: got %0d errors expected 0", s, we);
            end
        end
    endtask

    task automatic check_sequence(input string name, input int n, input int rx_n,
                                  input int we, input int ge, input int re,
                                  input int st, input int bc, input bit to);
        n_checks++;
        if (to || rx_n != n || st != n) begin
            n_fail++;
            $display("FAIL %s_count: got rx=%0d strobes=%0d timeout=%0b expected %0d/%0d/0",
                     name, rx_n, st, to, n, n);
        end
        n_checks++;
        if (ge != 0 || bc != n * FD) begin
            n_fail++;
            $display("FAIL %s_spacing: got gap_errors=%0d busy=%0d expected 0/%0d", name, ge, bc, n * FD);
        end
        n_checks++;
        if (re != 0 || we != 0) begin
            n_fail++;
            $display("FAIL %s_handshake_wave: got ready_errors=%0d wave_errors=%0d expected 0/0", name, re, we);
        end
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (rx_sym[i] !== tx_seq[i]) begin
                n_fail++;
                $display("FAIL %s_symbol_%0d: got %b expected %b", name, i, rx_sym[i], tx_seq[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int rx_n, we, ge, re, st, on, bc, lat;
        bit to;
        logic [1:0] seq [8] = '{2'b10, 2'b01, 2'b11, 2'b00, 2'b00, 2'b11, 2'b01, 2'b10};
        for (int i = 0; i < 8; i++) begin tx_seq[i] = seq[i]; rx_sym[i] = 2'bxx; end
        run_stream(8, 0, rx_n, we, ge, re, st, on, bc, lat, to);
        check_sequence("stream", 8, rx_n, we, ge, re, st, bc, to);
    endtask

    task automatic test_loopback();
        int rx_n, we, ge, re, st, on, bc, lat;
        bit to;
        logic [1:0] seq [4] = '{2'b11, 2'b00, 2'b01, 2'b10};
        for (int i = 0; i < 4; i++) begin tx_seq[i] = seq[i]; rx_sym[i] = 2'bxx; end
        run_stream(4, 0, rx_n, we, ge, re, st, on, bc, lat, to);
        check_sequence("loopback", 4, rx_n, we, ge, re, st, bc, to);
    endtask

    task automatic test_valid_toggle();
        int rx_n, we, ge, re, st, on, bc, lat;
        bit to;
        logic [1:0] seq [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
        for (int i = 0; i < 4; i++) begin tx_seq[i] = seq[i]; rx_sym[i] = 2'bxx; end
        run_stream(4, 1, rx_n, we, ge, re, st, on, bc, lat, to);
        check_sequence("toggle", 4, rx_n, we, ge, re, st, bc, to);
    endtask

    task automatic test_reset_mid_symbol();
        bit found;
        int strobes, busy_hi, ready_lo, dout_hi;
        found = 0;
        @(negedge clk);
        bus.sym_in = 2'b10; bus.sym_valid = 1'b1;
        @(negedge clk);
        bus.sym_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.clk_symbol === 1'b1) begin found = 1; break; end
            @(negedge clk);
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL midreset_strobe: got none expected strobe"); end
        // Fill the hold register so the reset must also discard it
        bus.sym_in = 2'b11; bus.sym_valid = 1'b1;
        @(negedge clk);
        bus.sym_valid = 1'b0;
        repeat (39) @(negedge clk);
        n_checks++;
        if (bus.dout !== 1'b1 || bus.sym_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_phase40: got dout=%b ready=%b expected 1/0", bus.dout, bus.sym_ready);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.dout !== 1'b0 || bus.clk_symbol !== 1'b0 || bus.sym_ready !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_async: got dout=%b strobe=%b ready=%b busy=%b expected 0/0/0/0",
                     bus.dout, bus.clk_symbol, bus.sym_ready, bus.busy);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.sym_ready !== 1'b0 || bus.dout !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_held: got ready=%b dout=%b expected 0/0", bus.sym_ready, bus.dout);
        end
        reset = 1'b1;
        strobes = 0; busy_hi = 0; ready_lo = 0; dout_hi = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.clk_symbol !== 1'b0) strobes++;
            if (bus.busy !== 1'b0) busy_hi++;
            if (bus.sym_ready !== 1'b1) ready_lo++;
            if (bus.dout !== 1'b0) dout_hi++;
        end
        n_checks++;
        if (strobes != 0 || dout_hi != 0) begin
            n_fail++;
            $display("FAIL midreset_no_strobe: got strobes=%0d dout_high=%0d expected 0/0", strobes, dout_hi);
        end
        n_checks++;
        if (busy_hi != 0 || ready_lo != 0) begin
            n_fail++;
            $display("FAIL midreset_idle: got busy_cycles=%0d not_ready_cycles=%0d expected 0/0", busy_hi, ready_lo);
        end
        $display("test_reset_mid_symbol done");
    endtask

    initial begin
        bus.sym_in    = 2'b00;
        bus.sym_valid = 1'b0;
        test_reset();
        test_single_symbol();
        test_all_symbols();
        test_back_to_back();
        test_reset_mid_symbol();
        test_loopback();
        test_valid_toggle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
